// File: rtl/coin_pulse_conditioner.sv
// Multi-channel coin sensor front end: synchronise, debounce, rising-edge pulse,
// and a saturating weighted credit accumulator with sticky saturation flag.
module coin_pulse_conditioner #(
  parameter int unsigned      CH     = 2,
  parameter int unsigned      SYNC   = 2,
  parameter int unsigned      DEB    = 4,
  parameter int unsigned      CW     = 8,
  parameter logic [CH*CW-1:0] WEIGHT = {8'd2, 8'd1}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] coin_in,
  input  logic          inhibit,
  input  logic          clr,
  output logic [CH-1:0] pulse,
  output logic [CW-1:0] credit,
  output logic          sat
);

  localparam int unsigned CNT_W = $clog2(DEB) + 1;
  localparam int unsigned SUM_W = CW + $clog2(CH) + 1;
  localparam logic [SUM_W-1:0] CMAX = {{(SUM_W-CW){1'b0}}, {CW{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);

  logic [CH-1:0][SYNC-1:0]  sync_q;
  logic [CH-1:0]            s;
  logic [CH-1:0]            lvl_q, lvl_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]            pulse_d;
  logic [SUM_W-1:0]         add, base, total;
  logic [CW-1:0]            credit_d;
  logic                     sat_d;

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      s[i] = sync_q[i][SYNC-1];
    end
  end

  // Debounce: a new level is accepted once it has mismatched for DEB cycles.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (s[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        lvl_d[i]   = s[i];
        cnt_d[i]   = '0;
        pulse_d[i] = s[i] & ~inhibit;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Weighted credit with saturation; clr only zeroes the base, so a same-cycle add survives.
  always_comb begin
    add = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (pulse[i]) begin
        add = add + SUM_W'(WEIGHT[i*CW +: CW]);
      end
    end
    base  = clr ? '0 : SUM_W'(credit);
    total = base + add;
    if (total > CMAX) begin
      credit_d = '1;
      sat_d    = 1'b1;
    end else begin
      credit_d = total[CW-1:0];
      sat_d    = clr ? 1'b0 : sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      pulse  <= '0;
      credit <= '0;
      sat    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC-2:0], coin_in[i]};
      end
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      pulse  <= pulse_d;
      credit <= credit_d;
      sat    <= sat_d;
    end
  end

endmodule
